// File: rtl/palette_ram_fader_if.sv
// Pixel, palette-write and fade control bundle for palette_ram_fader.
// The design side uses the slave modport; the driving side uses master.
interface palette_ram_fader_if #(
    parameter int unsigned INDEX_W   = 4,
    parameter int unsigned COLOR_W   = 4,
    parameter int unsigned NUM_BANKS = 2
);
    localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    logic                   frame_start;
    logic                   pix_valid;
    logic [INDEX_W-1:0]     pix_index;
    logic [BANK_W-1:0]      bank_sel;
    logic                   wr_en;
    logic [BANK_W-1:0]      wr_bank;
    logic [INDEX_W-1:0]     wr_addr;
    logic [3*COLOR_W-1:0]   wr_data;
    logic                   wr_ready;
    logic                   fade_start;
    logic                   fade_dir;
    logic                   fade_busy;
    logic                   fade_done;
    logic                   out_valid;
    logic [COLOR_W-1:0]     red;
    logic [COLOR_W-1:0]     green;
    logic [COLOR_W-1:0]     blue;

    modport slave (
        input  frame_start, pix_valid, pix_index, bank_sel,
        input  wr_en, wr_bank, wr_addr, wr_data,
        input  fade_start, fade_dir,
        output wr_ready, fade_busy, fade_done, out_valid, red, green, blue
    );

    modport master (
        output frame_start, pix_valid, pix_index, bank_sel,
        output wr_en, wr_bank, wr_addr, wr_data,
        output fade_start, fade_dir,
        input  wr_ready, fade_busy, fade_done, out_valid, red, green, blue
    );
endinterface

// File: rtl/palette_ram_fader.sv
// Multi-bank writable colour palette with frame-synchronous bank switching
// and a per-frame brightness fader; two-cycle pixel latency.
module palette_ram_fader #(
    parameter int unsigned INDEX_W   = 4,
    parameter int unsigned COLOR_W   = 4,
    parameter int unsigned NUM_BANKS = 2,
    parameter int unsigned FADE_DIV  = 2
) (
    input  logic               clk,
    input  logic               rst,
    palette_ram_fader_if.slave bus
);
    localparam int unsigned DEPTH  = 2**INDEX_W;
    localparam int unsigned TOTAL  = NUM_BANKS * DEPTH;
    localparam int unsigned ADDR_W = $clog2(TOTAL);
    localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int unsigned CNT_W  = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam int unsigned PIX_W  = 3 * COLOR_W;
    localparam int unsigned PW     = COLOR_W + 5;

    typedef enum logic {CLEAR, IDLE} ctl_t;
    typedef enum logic {F_IDLE, F_RUN} fade_t;

    logic [PIX_W-1:0]   mem [TOTAL];

    ctl_t               ctl, ctl_n;
    logic [ADDR_W-1:0]  clr_idx, clr_idx_n;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_wa;
    logic [PIX_W-1:0]   mem_wd;
    logic               wr_ready;

    logic [BANK_W-1:0]  active_bank;
    logic [ADDR_W-1:0]  rd_addr;
    logic [PIX_W-1:0]   s1_col;
    logic               s1_valid;
    logic               out_valid;
    logic [COLOR_W-1:0] red, green, blue;

    fade_t              fstate, fstate_n;
    logic [CNT_W-1:0]   fcnt, fcnt_n;
    logic               dir, dir_n;
    logic [4:0]         level, level_n;
    logic               done, done_n;
    logic [4:0]         target;

    function automatic logic [COLOR_W-1:0] scale(input logic [COLOR_W-1:0] c,
                                                 input logic [4:0] lvl);
        logic [PW-1:0] p;
        p = PW'(c) * PW'(lvl);
        return p[COLOR_W+3:4];
    endfunction

    // Palette controller: the single RAM write port is owned by CLEAR until it finishes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctl     <= CLEAR;
            clr_idx <= '0;
        end else begin
            ctl     <= ctl_n;
            clr_idx <= clr_idx_n;
        end
    end

    always_comb begin
        ctl_n     = ctl;
        clr_idx_n = clr_idx;
        mem_we    = 1'b0;
        mem_wa    = ADDR_W'({bus.wr_bank, bus.wr_addr});
        mem_wd    = bus.wr_data;
        wr_ready  = 1'b0;
        case (ctl)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_wa    = clr_idx;
                mem_wd    = '0;
                clr_idx_n = clr_idx + 1'b1;
                if (clr_idx == ADDR_W'(TOTAL - 1))
                    ctl_n = IDLE;
            end
            IDLE: begin
                wr_ready = 1'b1;
                mem_we   = bus.wr_en;
            end
            default: ctl_n = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_wa] <= mem_wd;
    end

    assign rd_addr = ADDR_W'({active_bank, bus.pix_index});

    // Pixel path; the RAM read sees the pre-write contents on a same-entry collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_bank <= '0;
            s1_col      <= '0;
            s1_valid    <= 1'b0;
            out_valid   <= 1'b0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
        end else begin
            if (bus.frame_start)
                active_bank <= bus.bank_sel;
            s1_col    <= mem[rd_addr];
            s1_valid  <= bus.pix_valid;
            out_valid <= s1_valid;
            red       <= s1_valid ? scale(s1_col[3*COLOR_W-1 -: COLOR_W], level) : '0;
            green     <= s1_valid ? scale(s1_col[2*COLOR_W-1 -: COLOR_W], level) : '0;
            blue      <= s1_valid ? scale(s1_col[COLOR_W-1:0], level) : '0;
        end
    end

    // Fader: a fresh start always wins over a coincident frame_start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fstate <= F_IDLE;
            fcnt   <= '0;
            dir    <= 1'b0;
            level  <= 5'd16;
            done   <= 1'b0;
        end else begin
            fstate <= fstate_n;
            fcnt   <= fcnt_n;
            dir    <= dir_n;
            level  <= level_n;
            done   <= done_n;
        end
    end

    assign target = dir ? 5'd16 : 5'd0;

    always_comb begin
        fstate_n = fstate;
        fcnt_n   = fcnt;
        dir_n    = dir;
        level_n  = level;
        done_n   = 1'b0;
        if (bus.fade_start) begin
            dir_n    = bus.fade_dir;
            fcnt_n   = '0;
            fstate_n = F_RUN;
        end else if (fstate == F_RUN) begin
            if (level == target) begin
                done_n   = 1'b1;
                fstate_n = F_IDLE;
            end else if (bus.frame_start) begin
                if (fcnt == CNT_W'(FADE_DIV - 1)) begin
                    fcnt_n  = '0;
                    level_n = dir ? level + 5'd1 : level - 5'd1;
                end else begin
                    fcnt_n = fcnt + 1'b1;
                end
            end
        end
    end

    assign bus.wr_ready  = wr_ready;
    assign bus.fade_busy = (fstate == F_RUN);
    assign bus.fade_done = done;
    assign bus.out_valid = out_valid;
    assign bus.red       = red;
    assign bus.green     = green;
    assign bus.blue      = blue;
endmodule

// File: tb/tb_palette_ram_fader.sv
// Self-checking bench for palette_ram_fader: directed scenarios plus random
// traffic compared every cycle against a behavioural palette/fader model.
module tb_palette_ram_fader;
    localparam int unsigned INDEX_W   = 4;
    localparam int unsigned COLOR_W   = 4;
    localparam int unsigned NUM_BANKS = 2;
    localparam int unsigned FADE_DIV  = 2;
    localparam int          ENTRIES   = 32;

    logic clk;
    logic rst;

    palette_ram_fader_if #(.INDEX_W(INDEX_W), .COLOR_W(COLOR_W), .NUM_BANKS(NUM_BANKS)) bus ();

    palette_ram_fader #(
        .INDEX_W(INDEX_W), .COLOR_W(COLOR_W), .NUM_BANKS(NUM_BANKS), .FADE_DIV(FADE_DIV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int done_seen = 0;

    // Behavioural model: palette contents, pipeline contents and fader level.
    int m_pal   [ENTRIES];
    bit m_known [ENTRIES];
    int m_s1_col, m_rgb, m_bank, m_level, m_frames, m_ci;
    bit m_s1_v, m_s1_k, m_ov, m_ok, m_run, m_dir, m_done, m_clearing;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int scale3(input int col, input int lvl);
        int r, g, b;
        r = ((col >> 8) & 15) * lvl / 16;
        g = ((col >> 4) & 15) * lvl / 16;
        b = (col & 15) * lvl / 16;
        return (r << 8) | (g << 4) | b;
    endfunction

    task automatic model_reset();
        m_s1_col = 0; m_s1_v = 0; m_s1_k = 1;
        m_rgb = 0; m_ov = 0; m_ok = 1;
        m_bank = 0; m_level = 16; m_run = 0; m_dir = 0; m_done = 0; m_frames = 0;
        m_clearing = 1; m_ci = 0;
    endtask

    task automatic model_step();
        int a;
        m_ov  = m_s1_v;
        m_rgb = m_s1_v ? scale3(m_s1_col, m_level) : 0;
        m_ok  = !m_s1_v || m_s1_k;
        a = m_bank * 16 + int'(bus.pix_index);
        m_s1_col = m_pal[a];
        m_s1_k   = m_known[a];
        m_s1_v   = bus.pix_valid;
        if (m_clearing) begin
            m_pal[m_ci] = 0;
            m_known[m_ci] = 1;
            m_ci++;
            if (m_ci == ENTRIES) m_clearing = 0;
        end else if (bus.wr_en) begin
            a = int'(bus.wr_bank) * 16 + int'(bus.wr_addr);
            m_pal[a] = int'(bus.wr_data);
            m_known[a] = 1;
        end
        if (bus.frame_start) m_bank = int'(bus.bank_sel);
        m_done = 0;
        if (bus.fade_start) begin
            m_run = 1; m_dir = bus.fade_dir; m_frames = 0;
        end else if (m_run) begin
            if (m_level == (m_dir ? 16 : 0)) begin
                m_run = 0; m_done = 1;
            end else if (bus.frame_start) begin
                m_frames++;
                if (m_frames == FADE_DIV) begin
                    m_frames = 0;
                    m_level += m_dir ? 1 : -1;
                end
            end
        end
    endtask

    // Compare on the falling edge; inputs are stable there until the next rising edge.
    initial begin
        for (int i = 0; i < ENTRIES; i++) begin
            m_pal[i] = 0;
            m_known[i] = 0;
        end
        model_reset();
        forever begin
            @(negedge clk);
            if (rst) model_reset();
            chk("out_valid", int'(bus.out_valid), int'(m_ov));
            if (m_ok) chk("rgb", int'({bus.red, bus.green, bus.blue}), m_rgb);
            chk("wr_ready", int'(bus.wr_ready), int'(!m_clearing));
            chk("fade_busy", int'(bus.fade_busy), int'(m_run));
            chk("fade_done", int'(bus.fade_done), int'(m_done));
            if (bus.fade_done) done_seen++;
            if (!rst) model_step();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (3) tick();
    endtask

    task automatic frame();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        tick();
        tick();
    endtask

    task automatic write(input int b, input int a, input int d);
        bus.wr_en   = 1'b1;
        bus.wr_bank = 1'(b);
        bus.wr_addr = 4'(a);
        bus.wr_data = 12'(d);
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_clear(input string name);
        int n;
        n = 0;
        while (bus.wr_ready !== 1'b1 && n < 100) begin
            bus.wr_en   = 1'($urandom);
            bus.wr_bank = 1'($urandom);
            bus.wr_addr = 4'($urandom);
            bus.wr_data = 12'($urandom);
            tick();
            n++;
        end
        bus.wr_en = 1'b0;
        chk(name, n, 32);
    endtask

    task automatic rgb_is(input string name, input int exp);
        chk(name, int'({bus.red, bus.green, bus.blue}), exp);
    endtask

    initial begin
        rst = 1'b1;
        bus.frame_start = 0; bus.pix_valid = 0; bus.pix_index = '0; bus.bank_sel = '0;
        bus.wr_en = 0; bus.wr_bank = '0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.fade_start = 0; bus.fade_dir = 0;
        repeat (3) tick();
        rst = 1'b0;
        wait_clear("clear_len");

        for (int b = 0; b < 2; b++) begin
            bus.bank_sel = 1'(b);
            frame();
            for (int i = 0; i < 16; i++) begin
                bus.pix_valid = 1'b1;
                bus.pix_index = 4'(i);
                tick();
            end
            bus.pix_valid = 1'b0;
            tick();
            tick();
        end

        write(0, 5, 'hAD6);
        write(1, 5, 'h8EF);
        bus.bank_sel = 1'b0;
        frame();
        bus.pix_valid = 1'b1;
        bus.pix_index = 4'd5;
        settle();
        rgb_is("bank0_idx5", 'hAD6);
        bus.bank_sel = 1'b1;
        settle();
        rgb_is("bank_hold_midframe", 'hAD6);
        frame();
        rgb_is("bank1_after_frame", 'h8EF);

        bus.pix_index = 4'd3;
        settle();
        bus.wr_en = 1'b1; bus.wr_bank = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 12'hFFF;
        tick();
        bus.wr_en = 1'b0;
        tick();
        rgb_is("collision_old", 'h000);
        tick();
        rgb_is("collision_new", 'hFFF);

        bus.fade_dir = 1'b0;
        bus.fade_start = 1'b1;
        tick();
        bus.fade_start = 1'b0;
        done_seen = 0;
        repeat (2) frame();
        rgb_is("fade_lvl15", 'hEEE);
        chk("model_lvl15", m_level, 15);
        repeat (30) frame();
        rgb_is("fade_black", 'h000);
        chk("fade_out_busy", int'(bus.fade_busy), 0);
        chk("fade_out_done_once", done_seen, 1);

        bus.fade_dir = 1'b1;
        bus.fade_start = 1'b1;
        tick();
        bus.fade_start = 1'b0;
        repeat (32) frame();
        chk("fade_in_full_busy", int'(bus.fade_busy), 0);
        chk("model_lvl16", m_level, 16);

        write(1, 3, 'hEEE);
        bus.fade_dir = 1'b0;
        bus.fade_start = 1'b1;
        tick();
        bus.fade_start = 1'b0;
        repeat (16) frame();
        settle();
        rgb_is("fade_lvl8", 'h777);
        chk("fade_lvl8_busy", int'(bus.fade_busy), 1);
        bus.fade_dir = 1'b1;
        bus.fade_start = 1'b1;
        bus.frame_start = 1'b1;
        tick();
        bus.fade_start = 1'b0;
        bus.frame_start = 1'b0;
        tick();
        tick();
        done_seen = 0;
        repeat (15) frame();
        rgb_is("reverse_lvl15", 'hDDD);
        chk("reverse_busy", int'(bus.fade_busy), 1);
        frame();
        rgb_is("reverse_full", 'hEEE);
        chk("reverse_done_once", done_seen, 1);

        done_seen = 0;
        bus.fade_start = 1'b1;
        tick();
        bus.fade_start = 1'b0;
        tick();
        tick();
        chk("at_target_done", done_seen, 1);

        bus.fade_dir = 1'b0;
        bus.fade_start = 1'b1;
        tick();
        bus.fade_start = 1'b0;
        repeat (3) frame();
        rst = 1'b1;
        #1;
        rgb_is("reset_rgb_now", 'h000);
        chk("reset_valid_now", int'(bus.out_valid), 0);
        chk("reset_busy_now", int'(bus.fade_busy), 0);
        tick();
        rst = 1'b0;
        repeat (10) begin
            bus.wr_en = 1'b1; bus.wr_bank = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 12'hABC;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_clear("clear_restart_len");
        bus.bank_sel = 1'b1;
        frame();
        settle();
        rgb_is("cleared_entry", 'h000);
        chk("model_lvl_reset", m_level, 16);

        repeat (4000) begin
            bus.frame_start = ($urandom % 8) == 0;
            bus.pix_valid   = 1'($urandom);
            bus.pix_index   = 4'($urandom);
            bus.bank_sel    = 1'($urandom);
            bus.wr_en       = ($urandom % 3) == 0;
            bus.wr_bank     = 1'($urandom);
            bus.wr_addr     = 4'($urandom);
            bus.wr_data     = 12'($urandom);
            bus.fade_start  = ($urandom % 40) == 0;
            bus.fade_dir    = 1'($urandom);
            rst             = ($urandom % 700) == 0;
            tick();
        end
        rst = 1'b0;
        bus.frame_start = 0; bus.pix_valid = 0; bus.wr_en = 0; bus.fade_start = 0;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
